hoaaned_add_scheduler: RTL and testbench

Shares one combinational hoaaned_adder instance among NUM_REQ requesters (e.g. PE-column partial-sum sources) via round-robin arbitration with valid/ready handshakes. Each granted operand pair is added in the same cycle. The result is captured in a one-entry output register tagged with the requester ID. The block sits between the PE array and the accumulator/writeback stage and also counts completed operations for profiling.

---
 rtl/hoaaned_sched_pkg.sv | 15 +
 rtl/hoaaned_add_scheduler_rr_arbiter.sv | 31 +++
 rtl/hoaaned_adder.sv | 31 +++
 rtl/hoaaned_add_scheduler.sv | 90 +++++++++
 tb/tb_hoaaned_add_scheduler.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/hoaaned_sched_pkg.sv
// Shared widths, slot-state encoding and helpers
// for the hoaaned adder scheduler.
package hoaaned_sched_pkg;

  localparam int DEF_ADDER_LENGTH   = 32;
  localparam int DEF_IMPRECISE_PART = 16;

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hoaaned_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester
// after ptr (wrapping) wins; en gates every grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          gnt
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    gnt   = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !gnt && req[j]) begin
        gnt      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hoaaned_adder.sv
// Approximate adder: exact upper part, constant/approximate
// low part with a single generated carry into the upper part.
module hoaaned_adder #(
  parameter int ADDER_LENGTH   = 32,
  parameter int IMPRECISE_PART = 16
) (
  input  logic [ADDER_LENGTH-1:0] a,
  input  logic [ADDER_LENGTH-1:0] b,
  output logic [ADDER_LENGTH:0]   sum
);

  localparam int IP = IMPRECISE_PART;
  localparam int UP = ADDER_LENGTH - IMPRECISE_PART;

  logic [UP:0] upper;
  logic        unused_low;

  assign upper = {1'b0, a[ADDER_LENGTH-1:IP]}
               + {1'b0, b[ADDER_LENGTH-1:IP]}
               + {{UP{1'b0}}, a[IP-1] & b[IP-1]};

  assign unused_low = ^{a[IP-3:0], b[IP-3:0]};

  always_comb begin
    sum                 = '1;
    sum[ADDER_LENGTH:IP] = upper;
    sum[IP-1] = (a[IP-1] ^ b[IP-1]) | (a[IP-2] & b[IP-2]);
    sum[IP-2] = a[IP-2] | b[IP-2];
  end

endmodule

// File: rtl/hoaaned_add_scheduler.sv
// Shares one hoaaned_adder among NUM_REQ requesters with
// round-robin grants and a one-entry tagged result slot.
module hoaaned_add_scheduler
  import hoaaned_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDER_LENGTH   = DEF_ADDER_LENGTH,
  parameter int IMPRECISE_PART = DEF_IMPRECISE_PART,
  parameter int ID_W           = id_width(NUM_REQ),
  parameter int CNT_W          = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [ADDER_LENGTH:0]           resp_sum,
  output logic [ID_W-1:0]                 resp_id,
  output logic [CNT_W-1:0]                op_count,
  output logic                            busy
);

  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         win;
  logic                    gnt_any;
  logic                    slot_free;
  logic                    arb_en;
  logic [ADDER_LENGTH-1:0] a_sel;
  logic [ADDER_LENGTH-1:0] b_sel;
  logic [ADDER_LENGTH:0]   sum;

  assign slot_free = (resp_valid == EMPTY) | resp_ready;
  assign arb_en    = en & slot_free & ~rst;
  assign busy      = resp_valid | (|req_valid);

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (req_ready),
    .idx   (win),
    .gnt   (gnt_any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        a_sel = req_a[i*ADDER_LENGTH +: ADDER_LENGTH];
        b_sel = req_b[i*ADDER_LENGTH +: ADDER_LENGTH];
      end
    end
  end

  hoaaned_adder #(
    .ADDER_LENGTH   (ADDER_LENGTH),
    .IMPRECISE_PART (IMPRECISE_PART)
  ) u_add (
    .a   (a_sel),
    .b   (b_sel),
    .sum (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= EMPTY;
      resp_sum   <= '0;
      resp_id    <= '0;
      op_count   <= '0;
      ptr        <= ID_W'(NUM_REQ - 1);
    end else if (gnt_any) begin
      resp_valid <= FULL;
      resp_sum   <= sum;
      resp_id    <= win;
      ptr        <= win;
      op_count   <= op_count + 1'b1;
    end else if (resp_ready) begin
      resp_valid <= EMPTY;
    end
  end

endmodule

// File: tb/tb_hoaaned_add_scheduler.sv
// Directed bench: vector table for single grants plus
// sequences for round-robin, backpressure, en and reset.
module tb_hoaaned_add_scheduler;

  localparam int N  = 4;
  localparam int AL = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [N-1:0]      req_valid;
  logic [N*AL-1:0]   req_a;
  logic [N*AL-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [AL:0]       resp_sum;
  logic [IW-1:0]     resp_id;
  logic [31:0]       op_count;
  logic              busy;

  int nvec = 0;
  int nerr = 0;
  int exp_cnt = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] sum;
  } vec_t;

  vec_t tbl[7];

  hoaaned_add_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id),
    .op_count   (op_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    tbl[0] = '{2, 32'h0001_0000, 32'h0002_0000, 33'h0_0003_3FFF};
    tbl[1] = '{0, 32'h0000_C000, 32'h0000_C000, 33'h0_0001_FFFF};
    tbl[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFF};
    tbl[3] = '{3, 32'h0000_0000, 32'h0000_0000, 33'h0_0000_3FFF};
    tbl[4] = '{1, 32'h1234_5678, 32'h0001_0000, 33'h0_1235_7FFF};
    tbl[5] = '{2, 32'h0000_8000, 32'h0000_4000, 33'h0_0000_FFFF};
    tbl[6] = '{1, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_3FFF};

    rst        = 1'b1;
    en         = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk); #1;
    chk("post_rst_count", 64'(op_count), 64'h0);
    chk("post_rst_valid", 64'(resp_valid), 64'h0);
    chk("idle_busy", 64'(busy), 64'h0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_a = '0;
      req_b = '0;
      req_a[tbl[i].id*AL +: AL] = tbl[i].a;
      req_b[tbl[i].id*AL +: AL] = tbl[i].b;
      req_valid = N'(1) << tbl[i].id;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready),
          64'(N'(1) << tbl[i].id));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'h1);
      @(posedge clk); #1;
      req_valid = '0;
      exp_cnt++;
      chk($sformatf("v%0d_sum", i), 64'(resp_sum), 64'(tbl[i].sum));
      chk($sformatf("v%0d_id", i), 64'(resp_id), 64'(tbl[i].id));
      chk($sformatf("v%0d_valid", i), 64'(resp_valid), 64'h1);
      chk($sformatf("v%0d_count", i), 64'(op_count), 64'(exp_cnt));
    end

    // reset with a full slot discards the result
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_valid", 64'(resp_valid), 64'h0);
    chk("midrst_count", 64'(op_count), 64'h0);

    rst       = 1'b0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++)
      req_a[i*AL +: AL] = 32'((i + 1) << 16);
    req_valid = '1;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk($sformatf("rr%0d_ready", g), 64'(req_ready),
          64'(N'(1) << (g % N)));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_id", g), 64'(resp_id), 64'(g % N));
      chk($sformatf("rr%0d_valid", g), 64'(resp_valid), 64'h1);
      chk($sformatf("rr%0d_sum", g), 64'(resp_sum),
          64'((((g % N) + 1) << 16) | 32'h3FFF));
      @(negedge clk);
    end
    chk("rr_count", 64'(op_count), 64'd6);

    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'h0);
      chk($sformatf("bp%0d_id", c), 64'(resp_id), 64'h1);
      chk($sformatf("bp%0d_sum", c), 64'(resp_sum), 64'h2_3FFF);
      chk($sformatf("bp%0d_valid", c), 64'(resp_valid), 64'h1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    chk("bp_release_id", 64'(resp_id), 64'h2);
    chk("bp_release_count", 64'(op_count), 64'd7);
    @(posedge clk); #1;
    chk("rr_next_id3", 64'(resp_id), 64'h3);
    @(posedge clk); #1;
    chk("rr_next_id0", 64'(resp_id), 64'h0);
    chk("rr_next_count", 64'(op_count), 64'd9);

    @(negedge clk);
    req_valid = 4'b1010;
    en        = 1'b0;
    #1;
    chk("en_lo_ready0", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    chk("en_lo_drain", 64'(resp_valid), 64'h0);
    @(negedge clk); #1;
    chk("en_lo_ready1", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    chk("en_lo_empty", 64'(resp_valid), 64'h0);
    chk("en_lo_count", 64'(op_count), 64'd9);
    chk("en_lo_id_hold", 64'(resp_id), 64'h0);
    @(negedge clk);
    en = 1'b1;
    #1;
    chk("en_hi_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    chk("en_hi_id", 64'(resp_id), 64'h1);
    chk("en_hi_sum", 64'(resp_sum), 64'h2_3FFF);
    chk("en_hi_count", 64'(op_count), 64'd10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
